// File: rtl/adder_pipeline.sv
// Pipelined ripple-slice adder/subtractor with valid/ready on both sides.
// Optional subtract mode is compiled in with `define ADDER_PIPE_SUB_EN.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

module adder_pipeline #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic             en, xfer;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign en       = out_ready | ~out_valid;
  assign in_ready = rst_n & en;
  assign xfer     = in_valid & in_ready;

`ifdef ADDER_PIPE_SUB_EN
  // Subtract folds into stage 0 as a + ~b + 1, so sub never needs to travel.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | ci;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c0         = ci;
`endif

  logic [STAGES-1:0][WIDTH-1:0] a_d, a_q, b_d, b_q, sum_d, sum_q;
  logic [STAGES-1:0][WIDTH-1:0] st_a, st_b, st_sum;
  logic [STAGES-1:0][SLICE-1:0] slice_s;
  logic [STAGES-1:0]            slice_c, st_c, c_d, c_q, vld_d, vld_q;
  logic                         ovf_d, ovf_q;

  // Stage k sees the raw operands at k=0, otherwise the previous stage register.
  always_comb begin
    st_a   = a_q;
    st_b   = b_q;
    st_c   = c_q;
    st_sum = sum_q;
    st_a[0]   = a;
    st_b[0]   = b_eff;
    st_c[0]   = c0;
    st_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k]   = a_q[k-1];
      st_b[k]   = b_q[k-1];
      st_c[k]   = c_q[k-1];
      st_sum[k] = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.W(SLICE)) u_slice (
      .a  (st_a[k][k*SLICE +: SLICE]),
      .b  (st_b[k][k*SLICE +: SLICE]),
      .ci (st_c[k]),
      .s  (slice_s[k]),
      .co (slice_c[k])
    );
  end

  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (en) begin
      vld_d[0] = xfer;
      for (int k = 1; k < STAGES; k++) vld_d[k] = vld_q[k-1];
      for (int k = 0; k < STAGES; k++) begin
        a_d[k]   = st_a[k];
        b_d[k]   = st_b[k];
        c_d[k]   = slice_c[k];
        sum_d[k] = st_sum[k];
        sum_d[k][k*SLICE +: SLICE] = slice_s[k];
      end
      ovf_d = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &
              (slice_s[LAST][SLICE-1] != st_a[LAST][WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_q[LAST];
  assign s         = sum_q[LAST];
  assign co        = c_q[LAST];
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_adder_pipeline.sv
// Bench for adder_pipeline (WIDTH=32, STAGES=4): scenario tasks plus a
// scoreboard that predicts every accepted operand set and checks each consumed result.
module tb_adder_pipeline;
  localparam int W  = 32;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, ci = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, co, ovf;
  logic [W-1:0] s;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] sbq[$];   // {co, ovf, s}

  adder_pipeline #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mci, input logic msub);
    logic [W-1:0] be;
    logic         c;
    logic [W:0]   r;
    logic         o;
    be = mb;
    c  = mci;
`ifdef ADDER_PIPE_SUB_EN
    if (msub) begin
      be = ~mb;
      c  = 1'b1;
    end
`endif
    r = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, c};
    o = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
    return {r[W], o, r[W-1:0]};
  endfunction

  // Inputs change only at posedge+1, so the negedge sees the handshake of the coming edge.
  always @(negedge clk) begin
    if (!rst_n) sbq.delete();
    else begin
      if (out_valid && out_ready) begin
        logic [W+1:0] exp;
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got s=%h co=%b ovf=%b, expected no result", s, co, ovf);
        end else begin
          exp = sbq.pop_front();
          if ({co, ovf, s} !== exp) begin
            bad++;
            $display("FAIL sb_result: got co=%b ovf=%b s=%h, expected co=%b ovf=%b s=%h",
                     co, ovf, s, exp[W+1], exp[W], exp[W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(a, b, ci, sub));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; ci = 1'($urandom);
      step();
      total++;
      if ({in_ready, out_valid, s, co, ovf} !== {2'b00, {W{1'b0}}, 2'b00}) begin
        bad++;
        $display("FAIL reset_state: got in_ready=%b out_valid=%b s=%h co=%b ovf=%b, expected all 0",
                 in_ready, out_valid, s, co, ovf);
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    step();
  endtask

  // One transfer, then check out_valid stays low until exactly the 4th edge.
  task automatic single_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tci, input logic tsub, input logic [W+1:0] req);
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int e = 1; e < ST; e++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s_early_valid: edge %0d got out_valid=%b expected 0", nm, e, out_valid);
      end
      step();
    end
    total++;
    if ({out_valid, co, ovf, s} !== {1'b1, req}) begin
      bad++;
      $display("FAIL %s_result: got v=%b co=%b ovf=%b s=%h, expected v=1 co=%b ovf=%b s=%h",
               nm, out_valid, co, ovf, s, req[W+1], req[W], req[W-1:0]);
    end
    step();
    sub = 1'b0;
  endtask

  task automatic test_ripple();
    single_op("ripple_carry", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
    single_op("ripple_ovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
  endtask

  task automatic test_sub();
`ifdef ADDER_PIPE_SUB_EN
    single_op("sub_mode", 32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
`else
    single_op("sub_mode", 32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0000_000C});
`endif
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      in_valid = (e <= 10);
      a = $urandom; b = $urandom; ci = 1'($urandom);
      step();
      total++;
      if (out_valid !== ((e >= ST) && (e <= 9 + ST))) begin
        bad++;
        $display("FAIL stream_valid: edge %0d got out_valid=%b", e, out_valid);
      end
    end
    in_valid = 1'b0;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL stream_drain: got %0d pending expected 0", sbq.size());
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] head;
    out_ready = 1'b1;
    for (int i = 0; i < ST; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; ci = 1'($urandom);
      step();
    end
    out_ready = 1'b0;
    a = $urandom; b = $urandom;
    #1;
    head = sbq[0];
    total++;
    if ({in_ready, out_valid} !== 2'b01) begin
      bad++;
      $display("FAIL bp_ready_drop: got in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({in_ready, out_valid, co, ovf, s} !== {2'b01, head}) begin
        bad++;
        $display("FAIL bp_hold: got rdy=%b v=%b co=%b ovf=%b s=%h expected rdy=0 v=1 co=%b ovf=%b s=%h",
                 in_ready, out_valid, co, ovf, s, head[W+1], head[W], head[W-1:0]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int e = 1; e <= ST + 1; e++) begin
      step();
      total++;
      if (out_valid !== (e < ST)) begin
        bad++;
        $display("FAIL bp_release_valid: edge %0d got out_valid=%b", e, out_valid);
      end
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL bp_drain: got %0d pending expected 0", sbq.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; ci = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if ({out_valid, s} !== {1'b0, {W{1'b0}}}) begin
      bad++;
      $display("FAIL midreset_clear: got out_valid=%b s=%h expected 0/0", out_valid, s);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midreset_ghost: cycle %0d got out_valid=%b expected 0", i, out_valid);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_ripple();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_sub();
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
